// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment decoder: segment fonts,
// controller states and the number of tracked digit positions.
package seg7_pkg;

    localparam int NUM_DIGITS = 6;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Active-low segment patterns, bit order g..a (bit 6 = g, bit 0 = a).
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Indexed by the hex value the pattern represents.
    localparam logic [6:0] SEG_TABLE [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

endpackage

// File: rtl/seg7_filter.sv
// Stability filter: counts consecutive identical strobed {segment, select}
// samples and pulses o_accept (combinationally, in the cycle of the
// STABLE_CYCLES-th sample) exactly once per stable run.
module seg7_filter
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [0:7] i_seg,
    input  logic [2:0] i_sel,
    input  logic       i_strobe,
    output logic       o_accept,
    output logic [0:7] o_seg,
    output logic [2:0] o_sel
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    logic [0:7] r_prev_seg;
    logic [2:0] r_prev_sel;
    logic       r_prev_ok;
    logic [3:0] r_cnt;

    logic       w_live;
    logic       w_match;
    logic [3:0] w_cnt_next;

    // Classify the current sample and compute the saturating run length.
    always_comb begin
        w_live     = i_strobe && (i_sel < 3'(NUM_DIGITS));
        w_match    = w_live && r_prev_ok && (i_seg == r_prev_seg) && (i_sel == r_prev_sel);
        w_cnt_next = 4'd0;
        if (w_match) begin
            w_cnt_next = (r_cnt == STABLE) ? r_cnt : r_cnt + 4'd1;
        end else if (w_live) begin
            w_cnt_next = 4'd1;
        end
    end

    // Accept fires only on the step from STABLE-1 to STABLE, so a saturated
    // run never re-accepts.
    assign o_accept = w_match && (r_cnt == STABLE - 4'd1);
    assign o_seg    = i_seg;
    assign o_sel    = i_sel;

    // Remember the last valid sample and the run length.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_seg <= '0;
            r_prev_sel <= '0;
            r_prev_ok  <= 1'b0;
            r_cnt      <= 4'd0;
        end else begin
            r_prev_ok <= w_live;
            r_cnt     <= w_cnt_next;
            if (w_live) begin
                r_prev_seg <= i_seg;
                r_prev_sel <= i_sel;
            end
        end
    end

endmodule

// File: rtl/seg7_decoder.sv
// Seven-segment pattern decoder with stability filter, change-only record
// emission over a valid/ready handshake, and a per-position value store.
// Optional macro SEG7_DECODER_HEX_EN enables decoding of A..F; without it
// those patterns are reported as errors.
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [0:7]  SEG_IN,
    input  logic [2:0]  SEG_SEL,
    input  logic        SEG_STROBE,
    output logic        DIG_VALID,
    input  logic        DIG_READY,
    output logic [3:0]  DIG_VALUE,
    output logic [2:0]  DIG_INDEX,
    output logic        DIG_DP,
    output logic        DIG_ERR,
    output logic [0:23] DIGITS
);

`ifdef SEG7_DECODER_HEX_EN
    localparam int HEX_LIMIT = 16;
`else
    localparam int HEX_LIMIT = 10;
`endif

    // Returns {err, value}; unknown patterns give err=1, value=0.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] res;
        res = {1'b1, 4'h0};
        for (int v = 0; v < HEX_LIMIT; v++) begin
            if (pat == SEG_TABLE[v]) res = {1'b0, 4'(v)};
        end
        return res;
    endfunction

    logic       w_accept;
    logic [0:7] w_acc_seg;
    logic [2:0] w_acc_sel;

    seg7_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .i_clk    (CLOCK_50),
        .i_rst_n  (RESET_N),
        .i_seg    (SEG_IN),
        .i_sel    (SEG_SEL),
        .i_strobe (SEG_STROBE),
        .o_accept (w_accept),
        .o_seg    (w_acc_seg),
        .o_sel    (w_acc_sel)
    );

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_valid;
    logic [3:0]            r_value;
    logic [2:0]            r_index;
    logic                  r_dp;
    logic                  r_err;
    logic [0:23]           r_digits;
    logic [NUM_DIGITS-1:0] r_pos_dp;
    logic [NUM_DIGITS-1:0] r_pos_err;
    logic [NUM_DIGITS-1:0] r_pos_seen;

    logic [4:0] w_dec;
    logic       w_new_dp;
    logic [3:0] w_old_val;
    logic       w_old_dp;
    logic       w_old_err;
    logic       w_old_seen;
    logic       w_changed;
    logic       w_emit;

    // Decode the accepted pattern and fetch the stored record for its position.
    always_comb begin
        w_dec      = decode_seg(w_acc_seg[1:7]);
        w_new_dp   = ~w_acc_seg[0];
        w_old_val  = 4'h0;
        w_old_dp   = 1'b0;
        w_old_err  = 1'b0;
        w_old_seen = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_acc_sel == 3'(i)) begin
                w_old_val  = r_digits[4*i +: 4];
                w_old_dp   = r_pos_dp[i];
                w_old_err  = r_pos_err[i];
                w_old_seen = r_pos_seen[i];
            end
        end
        w_changed = !w_old_seen || (w_dec[3:0] != w_old_val) ||
                    (w_new_dp != w_old_dp) || (w_dec[4] != w_old_err);
    end

    // Next state: emit only from IDLE on a changed acceptance; EMIT drops
    // any acceptance, including one coinciding with the handshake.
    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_changed) begin
                    w_emit       = 1'b1;
                    w_state_next = EMIT;
                end
            end
            EMIT: begin
                if (DIG_READY) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, output record and per-position store update together on emission.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_value    <= 4'h0;
            r_index    <= 3'd0;
            r_dp       <= 1'b0;
            r_err      <= 1'b0;
            r_digits   <= '0;
            r_pos_dp   <= '0;
            r_pos_err  <= '0;
            r_pos_seen <= '0;
        end else begin
            r_state <= w_state_next;
            r_valid <= (w_state_next == EMIT);
            if (w_emit) begin
                r_value <= w_dec[3:0];
                r_index <= w_acc_sel;
                r_dp    <= w_new_dp;
                r_err   <= w_dec[4];
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (w_acc_sel == 3'(i)) begin
                        r_digits[4*i +: 4] <= w_dec[3:0];
                        r_pos_dp[i]        <= w_new_dp;
                        r_pos_err[i]       <= w_dec[4];
                        r_pos_seen[i]      <= 1'b1;
                    end
                end
            end
        end
    end

    assign DIG_VALID = r_valid;
    assign DIG_VALUE = r_value;
    assign DIG_INDEX = r_index;
    assign DIG_DP    = r_dp;
    assign DIG_ERR   = r_err;
    assign DIGITS    = r_digits;

endmodule

// File: tb/tb_seg7_decoder.sv
// Self-checking bench for seg7_decoder: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_seg7_decoder;

    localparam int STABLE = 4;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N = 1'b0;
    logic [0:7]  SEG_IN = 8'hFF;
    logic [2:0]  SEG_SEL = 3'd0;
    logic        SEG_STROBE = 1'b0;
    logic        DIG_VALID;
    logic        DIG_READY = 1'b0;
    logic [3:0]  DIG_VALUE;
    logic [2:0]  DIG_INDEX;
    logic        DIG_DP;
    logic        DIG_ERR;
    logic [0:23] DIGITS;

    int n_checks = 0;
    int n_fail = 0;

    seg7_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .SEG_IN     (SEG_IN),
        .SEG_SEL    (SEG_SEL),
        .SEG_STROBE (SEG_STROBE),
        .DIG_VALID  (DIG_VALID),
        .DIG_READY  (DIG_READY),
        .DIG_VALUE  (DIG_VALUE),
        .DIG_INDEX  (DIG_INDEX),
        .DIG_DP     (DIG_DP),
        .DIG_ERR    (DIG_ERR),
        .DIGITS     (DIGITS)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

`ifdef SEG7_DECODER_HEX_EN
    localparam int DEC_LIMIT = 16;
`else
    localparam int DEC_LIMIT = 10;
`endif

    // Seven-segment font, g..a, active low, indexed by displayed value.
    logic [6:0] font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_decode(input logic [6:0] pat, output int val, output bit err);
        val = 0;
        err = 1'b1;
        for (int v = 0; v < DEC_LIMIT; v++) begin
            if (pat == font[v]) begin
                val = v;
                err = 1'b0;
            end
        end
    endfunction

    // Reference model state.
    logic [0:7] m_last_seg = '0;
    int         m_last_sel = 0;
    bit         m_last_ok = 0;
    int         m_run = 0;
    bit         m_pending = 0;
    int         m_rec_val = 0;
    int         m_rec_idx = 0;
    bit         m_rec_dp = 0;
    bit         m_rec_err = 0;
    int         m_digit [6] = '{0, 0, 0, 0, 0, 0};
    bit         m_dp [6] = '{0, 0, 0, 0, 0, 0};
    bit         m_err [6] = '{0, 0, 0, 0, 0, 0};
    bit         m_seen [6] = '{0, 0, 0, 0, 0, 0};

    // Model: run-length stability counter, then one pending record at a time.
    always @(posedge CLOCK_50 or negedge RESET_N) begin
        bit acc;
        int v;
        bit e;
        bit d;
        int s;
        if (!RESET_N) begin
            m_last_ok = 0;
            m_run = 0;
            m_pending = 0;
            m_rec_val = 0; m_rec_idx = 0; m_rec_dp = 0; m_rec_err = 0;
            for (int i = 0; i < 6; i++) begin
                m_digit[i] = 0; m_dp[i] = 0; m_err[i] = 0; m_seen[i] = 0;
            end
        end else begin
            acc = 0;
            s = int'(SEG_SEL);
            if (!SEG_STROBE || s >= 6) begin
                m_run = 0;
                m_last_ok = 0;
            end else begin
                if (m_last_ok && SEG_IN == m_last_seg && s == m_last_sel) begin
                    if (m_run < STABLE) begin
                        m_run++;
                        if (m_run == STABLE) acc = 1;
                    end
                end else begin
                    m_run = 1;
                end
                m_last_ok = 1;
                m_last_seg = SEG_IN;
                m_last_sel = s;
            end
            if (m_pending) begin
                if (DIG_READY) m_pending = 0;
            end else if (acc) begin
                m_decode(SEG_IN[1:7], v, e);
                d = ~SEG_IN[0];
                if (!m_seen[s] || m_digit[s] != v || m_dp[s] != d || m_err[s] != e) begin
                    m_pending = 1;
                    m_rec_val = v; m_rec_idx = s; m_rec_dp = d; m_rec_err = e;
                    m_digit[s] = v; m_dp[s] = d; m_err[s] = e; m_seen[s] = 1;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge CLOCK_50) begin
        chk("valid", int'(DIG_VALID), int'(m_pending));
        if (m_pending) begin
            chk("value", int'(DIG_VALUE), m_rec_val);
            chk("index", int'(DIG_INDEX), m_rec_idx);
            chk("dp", int'(DIG_DP), int'(m_rec_dp));
            chk("err", int'(DIG_ERR), int'(m_rec_err));
        end
        for (int i = 0; i < 6; i++) begin
            chk("digits_pos", int'(DIGITS[4*i +: 4]), m_digit[i]);
        end
    end

    task automatic cyc(input logic [7:0] seg, input logic [2:0] sel,
                       input logic stb, input logic rdy, input int n);
        for (int k = 0; k < n; k++) begin
            SEG_IN = seg;
            SEG_SEL = sel;
            SEG_STROBE = stb;
            DIG_READY = rdy;
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    initial begin
        logic [7:0] rseg;
        logic [2:0] rsel;
        int len;

        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("reset_valid", int'(DIG_VALID), 0);
        chk("reset_digits", int'(DIGITS), 0);
        chk("reset_value", int'(DIG_VALUE), 0);
        RESET_N = 1'b1;
        cyc(8'hFF, 3'd0, 1'b0, 1'b0, 2);

        // Basic emit of "1" on position 2.
        cyc(8'b11111001, 3'd2, 1'b1, 1'b0, 3);
        chk("basic_early", int'(DIG_VALID), 0);
        cyc(8'b11111001, 3'd2, 1'b1, 1'b0, 1);
        chk("basic_valid", int'(DIG_VALID), 1);
        chk("basic_value", int'(DIG_VALUE), 1);
        chk("basic_index", int'(DIG_INDEX), 2);
        chk("basic_dp", int'(DIG_DP), 0);
        chk("basic_err", int'(DIG_ERR), 0);
        chk("basic_digits", int'(DIGITS[8:11]), 1);
        cyc(8'hFF, 3'd0, 1'b0, 1'b0, 2);
        chk("hold_valid", int'(DIG_VALID), 1);
        chk("hold_value", int'(DIG_VALUE), 1);
        cyc(8'hFF, 3'd0, 1'b0, 1'b1, 1);
        chk("handshake_idle", int'(DIG_VALID), 0);

        // Re-present stored value and an out-of-range select: both silent.
        cyc(8'b11111001, 3'd2, 1'b1, 1'b0, 5);
        chk("nochange_valid", int'(DIG_VALID), 0);
        cyc(8'b11111001, 3'd6, 1'b1, 1'b0, 5);
        chk("sel6_valid", int'(DIG_VALID), 0);
        chk("sel6_digits", int'(DIGITS), 24'h001000);

        // Unstable input on position 3.
        cyc(8'b11111001, 3'd3, 1'b1, 1'b0, 3);
        cyc(8'b10100100, 3'd3, 1'b1, 1'b0, 3);
        chk("unstable_valid", int'(DIG_VALID), 0);
        cyc(8'b10100100, 3'd3, 1'b1, 1'b0, 1);
        chk("unstable_value", int'(DIG_VALUE), 2);
        chk("unstable_index", int'(DIG_INDEX), 3);
        cyc(8'hFF, 3'd0, 1'b0, 1'b1, 1);

        // "A" on position 0.
        cyc(8'b10001000, 3'd0, 1'b1, 1'b0, 4);
        chk("hex_valid", int'(DIG_VALID), 1);
`ifdef SEG7_DECODER_HEX_EN
        chk("hex_value", int'(DIG_VALUE), 10);
        chk("hex_err", int'(DIG_ERR), 0);
`else
        chk("hex_value", int'(DIG_VALUE), 0);
        chk("hex_err", int'(DIG_ERR), 1);
`endif
        cyc(8'hFF, 3'd0, 1'b0, 1'b1, 1);

        // Backpressure: "5" on position 4 held; "3" on position 1 is dropped.
        cyc(8'b10010010, 3'd4, 1'b1, 1'b0, 4);
        cyc(8'b10110000, 3'd1, 1'b1, 1'b0, 4);
        chk("bp_index", int'(DIG_INDEX), 4);
        chk("bp_value", int'(DIG_VALUE), 5);
        chk("bp_dropped", int'(DIGITS[4:7]), 0);
        cyc(8'hFF, 3'd0, 1'b0, 1'b1, 1);
        chk("bp_release", int'(DIG_VALID), 0);
        cyc(8'b10110000, 3'd1, 1'b1, 1'b0, 4);
        chk("bp_re_value", int'(DIG_VALUE), 3);
        chk("bp_re_index", int'(DIG_INDEX), 1);
        cyc(8'hFF, 3'd0, 1'b0, 1'b1, 1);

        // Reset in the middle of an emission.
        cyc(8'b11111000, 3'd5, 1'b1, 1'b0, 4);
        chk("pre_reset_valid", int'(DIG_VALID), 1);
        #3;
        RESET_N = 1'b0;
        #1;
        chk("async_reset_valid", int'(DIG_VALID), 0);
        chk("async_reset_digits", int'(DIGITS), 0);
        @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b1;
        cyc(8'hFF, 3'd0, 1'b0, 1'b1, 2);
        chk("post_reset_valid", int'(DIG_VALID), 0);

        // Randomized traffic.
        for (int b = 0; b < 400; b++) begin
            if ($urandom_range(0, 7) == 0)
                rseg[6:0] = 7'($urandom);
            else
                rseg[6:0] = font[$urandom_range(0, 15)];
            rseg[7] = 1'($urandom);
            rseg = {rseg[7], rseg[6:0]};
            if ($urandom_range(0, 7) == 0)
                rsel = 3'($urandom_range(6, 7));
            else
                rsel = 3'($urandom_range(0, 5));
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                cyc(rseg, rsel, ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0), 1);
            end
            if ($urandom_range(0, 99) == 0) begin
                RESET_N = 1'b0;
                @(posedge CLOCK_50);
                #1;
                RESET_N = 1'b1;
            end
        end
        cyc(8'hFF, 3'd0, 1'b0, 1'b1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_decoder.md
SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 STABLE_CYCLES, 4, consecutive identical strobed samples needed to accept a pattern (legal range 2..15).
REQ-002 NUM_DIGITS, 6, number of digit positions tracked (fixed at 6; SEG_SEL values 0..5).
REQ-003 CLOCK_50  input  1  sole clock, rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SEG_IN  input  [0:7]  active-low segment pattern: index 0 = DP, 1 = g, 2 = f, 3 = e, 4 = d, 5 = c, 6 = b, 7 = a.
REQ-006 SEG_SEL  input  3  digit position the pattern belongs to.
REQ-007 SEG_STROBE  input  1  SEG_IN/SEG_SEL valid this cycle.
REQ-008 DIG_VALID  output  1  decoded digit record pending.
REQ-009 DIG_READY  input  1  consumer accepts the record when DIG_VALID && DIG_READY.
REQ-010 DIG_VALUE  output  4  decoded hex value.
REQ-011 DIG_INDEX  output  3  position of the record.
REQ-012 DIG_DP  output  1  decimal point lit (SEG_IN[0] == 0).
REQ-013 DIG_ERR  output  1  pattern not in the decode table.
REQ-014 DIGITS  output  [0:23]  last accepted value per position; position i at bits [4i:4i+3].

Function
REQ-015 Filter: a sample is a matching sample when SEG_STROBE=1, SEG_SEL<6, and {SEG_IN,SEG_SEL} equals the previous cycle's sample; a count of consecutive matches is kept.
REQ-016 Filter count resets to 1 on a new strobed pair, and to 0 on SEG_STROBE=0 or SEG_SEL>=6.
REQ-017 Acceptance: occurs once when the count reaches STABLE_CYCLES; the count then saturates, and no re-acceptance occurs until the pair changes or the strobe drops.
REQ-018 Decode table:
- Active-low 7-segment patterns 0..9 and A,b,C,d,E,F (e.g. 1 = 7'b1111001 on g..a, A = 7'b0001000).
- Any other pattern, including blank: DIG_ERR=1, DIG_VALUE=0.
REQ-019 State machine: IDLE -> (acceptance) -> EMIT; EMIT -> (DIG_READY=1) -> IDLE.
REQ-020 Change-only emission: on acceptance in IDLE, enter EMIT only if the position has never been accepted since reset, or its decoded value/DP/ERR differs from the stored record; otherwise stay in IDLE.
REQ-021 On emission, update DIGITS for that position and the stored DP/ERR in the same edge; DIG_VALID rises in the cycle after the edge that captured the STABLE_CYCLES-th sample.
REQ-022 DIG_VALUE/INDEX/DP/ERR stay constant while DIG_VALID=1 and DIG_READY=0.
REQ-023 Acceptance while in EMIT is dropped: no stored update and no queueing; the filter keeps running.
REQ-024 Acceptance on the same edge that DIG_READY completes a handshake is dropped (IDLE entered).
REQ-025 Back-to-back records: minimum spacing is one IDLE cycle between handshakes.

Reset
REQ-026 RESET_N=0 immediately forces:
- IDLE state, DIG_VALID=0, DIG_VALUE=0, DIG_INDEX=0, DIG_DP=0, DIG_ERR=0;
- DIGITS all zero, filter count 0, all positions marked never-accepted.
REQ-027 Reset asserted during EMIT drops the pending record; the record is not re-emitted unless the pattern is re-accepted after release.

Configuration
REQ-028 With SEG7_DECODER_HEX_EN defined, patterns A..F decode to 4'hA..4'hF.
REQ-029 Without SEG7_DECODER_HEX_EN, patterns A..F are treated as undecodable: DIG_ERR=1, DIG_VALUE=0.

Structure
REQ-030 Package seg7_pkg holds the 16 segment-pattern constants, the state enum (IDLE, EMIT), and the NUM_DIGITS constant.
REQ-031 The stability filter is sub-module seg7_filter (inputs: sample and strobe; output: one-cycle accept pulse plus the captured pair).

Verification
REQ-032 Reset: assert RESET_N=0 mid-EMIT -> DIG_VALID=0 and DIGITS=24'h0 without waiting for a clock edge.
REQ-033 Basic emit: SEG_IN=8'b11111001, SEG_SEL=2, strobed 4 cycles -> DIG_VALID=1 next cycle with VALUE=1, INDEX=2, DP=0, ERR=0; DIGITS[8:11]=1.
REQ-034 Unstable input: same pattern for 3 cycles, then 8'b10100100 -> no DIG_VALID until the new pattern has 4 matches, then VALUE=2.
REQ-035 Hex decode: SEG_IN=8'b10001000, SEG_SEL=0, 4 cycles -> with macro, VALUE=4'hA, ERR=0; without macro, VALUE=0, ERR=1.
REQ-036 Backpressure: hold DIG_READY=0 and accept digit 3 on position 1 -> record dropped, DIGITS unchanged; after handshake, re-present for 4 cycles -> VALUE=3, INDEX=1.
REQ-037 No-change suppression: re-present the already-stored 1 on position 2 -> no DIG_VALID; present the same pattern on SEG_SEL=6 -> ignored.
